// File: rtl/register_stack_engine.sv
// rtl/register_stack_engine.sv - multi-register push/pop sequencer for maxicore32
//
// Spills a masked register set to a full-descending stack (push) or fills it
// back (pop). The register file performs all SP arithmetic; this block only
// issues dec/inc requests and uses the SP read port as the memory address.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   start, pop, mask,      operation request, sampled only while idle
//   sp_index
//   busy, done             not-idle flag, one-cycle completion pulse
//   rf_read_*              source register for a push
//   rf_sp_*                stack-pointer read port (index = latched sp_index)
//   rf_write*              register fill on pop
//   rf_inc, rf_dec,        stack-pointer adjust by SP_STEP
//   rf_incdec_index
//   mem_*                  32-bit memory bus: address, data, strobes, ready
//
// Build option: define REGSTACK_WAIT_EN to honour mem_ready; otherwise memory
// is taken as single-cycle and mem_ready is ignored.
module register_stack_engine #(
    parameter int SP_STEP = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pop,
    input  logic [15:0] mask,
    input  logic [3:0]  sp_index,
    output logic        busy,
    output logic        done,
    output logic [3:0]  rf_read_index,
    input  logic [31:0] rf_read_data,
    output logic [3:0]  rf_sp_index,
    input  logic [31:0] rf_sp_data,
    output logic        rf_write,
    output logic [3:0]  rf_write_index,
    output logic [31:0] rf_write_data,
    output logic        rf_inc,
    output logic        rf_dec,
    output logic [3:0]  rf_incdec_index,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_WRITE,
        S_READ,
        S_DONE
    } t_state;

    t_state      r_state;
    t_state      w_next_state;
    logic        r_pop;
    logic [3:0]  r_sp_index;
    logic [15:0] r_mask;

    logic [15:0] w_start_mask;
    logic [15:0] w_cur_onehot;
    logic [15:0] w_mask_left;
    logic [3:0]  w_hi_index;
    logic [3:0]  w_lo_index;
    logic [3:0]  w_cur_index;
    logic        w_ready;
    logic        w_unused_ready;
    logic [31:0] w_unused_step;

`ifdef REGSTACK_WAIT_EN
    assign w_ready        = mem_ready;
    assign w_unused_ready = 1'b0;
`else
    assign w_ready        = 1'b1;
    assign w_unused_ready = mem_ready;
`endif

    // The step itself is applied inside the register file.
    assign w_unused_step = 32'(SP_STEP);

    // The SP register is never part of the transfer set.
    assign w_start_mask = mask & ~(16'd1 << sp_index);

    // Push walks the mask from the top so that the lowest register ends up at
    // the lowest address; pop walks from the bottom to undo it.
    always_comb begin
        w_hi_index = 4'd0;
        w_lo_index = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (r_mask[i]) w_hi_index = i[3:0];
        end
        for (int i = 15; i >= 0; i--) begin
            if (r_mask[i]) w_lo_index = i[3:0];
        end
    end

    assign w_cur_index  = r_pop ? w_lo_index : w_hi_index;
    assign w_cur_onehot = 16'd1 << w_cur_index;
    assign w_mask_left  = r_mask & ~w_cur_onehot;
    assign rf_sp_index  = r_sp_index;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pop      <= 1'b0;
            r_sp_index <= 4'd0;
            r_mask     <= 16'd0;
        end else if (r_state == S_IDLE && start) begin
            r_pop      <= pop;
            r_sp_index <= sp_index;
            r_mask     <= w_start_mask;
        end else if ((r_state == S_WRITE || r_state == S_READ) && w_ready) begin
            r_mask     <= w_mask_left;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        busy            = (r_state != S_IDLE);
        done            = 1'b0;
        rf_read_index   = 4'd0;
        rf_write        = 1'b0;
        rf_write_index  = 4'd0;
        rf_write_data   = 32'd0;
        rf_inc          = 1'b0;
        rf_dec          = 1'b0;
        rf_incdec_index = 4'd0;
        mem_address     = 32'd0;
        mem_data_out    = 32'd0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_start_mask == 16'd0) w_next_state = S_DONE;
                    else if (pop)              w_next_state = S_READ;
                    else                       w_next_state = S_DEC;
                end
            end
            S_DEC: begin
                rf_dec          = 1'b1;
                rf_incdec_index = r_sp_index;
                w_next_state    = S_WRITE;
            end
            S_WRITE: begin
                // SP was decremented on the previous edge, so it already
                // points at the free slot.
                mem_address   = rf_sp_data;
                rf_read_index = w_cur_index;
                mem_data_out  = rf_read_data;
                mem_write     = 1'b1;
                if (w_ready) begin
                    w_next_state = (w_mask_left == 16'd0) ? S_DONE : S_DEC;
                end
            end
            S_READ: begin
                mem_address = rf_sp_data;
                mem_read    = 1'b1;
                if (w_ready) begin
                    // Fill and SP increment retire on the same edge; the SP
                    // is excluded from the mask so the indices never collide.
                    rf_write        = 1'b1;
                    rf_write_index  = w_cur_index;
                    rf_write_data   = mem_data_in;
                    rf_inc          = 1'b1;
                    rf_incdec_index = r_sp_index;
                    w_next_state    = (w_mask_left == 16'd0) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_register_stack_engine.sv
// tb/tb_register_stack_engine.sv - randomized self-checking bench for register_stack_engine
module tb_register_stack_engine;

    localparam int STEP = 4;
`ifdef REGSTACK_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        pop      = 1'b0;
    logic [15:0] mask     = 16'd0;
    logic [3:0]  sp_index = 4'd0;
    logic        busy, done;
    logic [3:0]  rf_read_index, rf_sp_index, rf_write_index, rf_incdec_index;
    logic [31:0] rf_read_data, rf_sp_data, rf_write_data;
    logic        rf_write, rf_inc, rf_dec;
    logic [31:0] mem_address, mem_data_out;
    logic [31:0] mem_data_in = 32'd0;
    logic        mem_read, mem_write, mem_ready;

    logic [31:0] regs [16];
    logic [31:0] mem [logic [31:0]];
    int          wait_cnt = 0;
    int          cur_wait = 0;
    logic        ld_en  = 1'b0;
    logic [3:0]  ld_idx = 4'd0;
    logic [31:0] ld_val = 32'd0;

    int          wr_cnt = 0;
    logic [31:0] wr_addr [1024];
    logic [31:0] wr_data [1024];
    int          dec_cyc = 0, inc_cyc = 0, rfw_cyc = 0, strobe_cyc = 0;

    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    register_stack_engine #(.SP_STEP(STEP)) dut (
        .clock(clock), .reset(reset), .start(start), .pop(pop), .mask(mask),
        .sp_index(sp_index), .busy(busy), .done(done),
        .rf_read_index(rf_read_index), .rf_read_data(rf_read_data),
        .rf_sp_index(rf_sp_index), .rf_sp_data(rf_sp_data),
        .rf_write(rf_write), .rf_write_index(rf_write_index), .rf_write_data(rf_write_data),
        .rf_inc(rf_inc), .rf_dec(rf_dec), .rf_incdec_index(rf_incdec_index),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5a5a_0f0f;
    endfunction

    // Register file, memory and wait-state generator seen by the DUT.
    assign rf_read_data = regs[rf_read_index];
    assign rf_sp_data   = regs[rf_sp_index];
    assign mem_ready    = (wait_cnt >= cur_wait);

    always @(negedge clock) mem_data_in = mem_rd(mem_address);

    always @(posedge clock) begin
        if (ld_en)    regs[ld_idx] <= ld_val;
        if (rf_write) regs[rf_write_index] <= rf_write_data;
        if (rf_inc)   regs[rf_incdec_index] <= regs[rf_incdec_index] + 32'(STEP);
        if (rf_dec)   regs[rf_incdec_index] <= regs[rf_incdec_index] - 32'(STEP);
        if (mem_write && (mem_ready || !WAIT_EN)) begin
            mem[mem_address] = mem_data_out;
            if (wr_cnt < 1024) begin
                wr_addr[wr_cnt] = mem_address;
                wr_data[wr_cnt] = mem_data_out;
            end
            wr_cnt++;
        end
        if (rf_dec)                dec_cyc++;
        if (rf_inc)                inc_cyc++;
        if (rf_write)              rfw_cyc++;
        if (mem_read || mem_write) strobe_cyc++;
        if (reset || !(mem_read || mem_write) || mem_ready) wait_cnt <= 0;
        else                                                 wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_reg(input logic [3:0] idx, input logic [31:0] v);
        @(negedge clock);
        ld_en  = 1'b1;
        ld_idx = idx;
        ld_val = v;
        @(posedge clock);
        #1 ld_en = 1'b0;
    endtask

    // Runs one operation and compares against a model built from the
    // stack rules: push stores highest register at highest address, SP
    // moves one step per register, latency depends only on count and waits.
    task automatic do_op(input logic p, input logic [15:0] m, input logic [3:0] spi,
                         input int w, input bit inject, input string tag);
        logic [31:0] mr [16];
        logic [31:0] ea [$];
        logic [31:0] ed [$];
        logic [15:0] eff;
        logic [31:0] sp, hold_a, hold_d;
        logic [1:0]  hold_s;
        logic        hold_v;
        int          n, exp_lat, lat, wb, db, ib, fb, sb, we;
        @(negedge clock);
        for (int i = 0; i < 16; i++) mr[i] = regs[i];
        eff      = m;
        eff[spi] = 1'b0;
        n        = $countones(eff);
        sp       = mr[spi];
        if (p) begin
            for (int i = 0; i < 16; i++) if (eff[i]) begin
                mr[i] = mem_rd(sp);
                sp    = sp + 32'(STEP);
            end
        end else begin
            for (int i = 15; i >= 0; i--) if (eff[i]) begin
                sp = sp - 32'(STEP);
                ea.push_back(sp);
                ed.push_back(mr[i]);
            end
        end
        mr[spi] = sp;
        we      = WAIT_EN ? w : 0;
        if (n == 0) exp_lat = 1;
        else        exp_lat = p ? n * (1 + we) + 1 : n * (2 + we) + 1;

        wb = wr_cnt; db = dec_cyc; ib = inc_cyc; fb = rfw_cyc; sb = strobe_cyc;
        pop = p; mask = m; sp_index = spi; cur_wait = w; start = 1'b1;
        hold_v = 1'b0; hold_a = '0; hold_d = '0; hold_s = '0;
        lat = 0;
        @(posedge clock);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (hold_v) begin
                check({tag, "/hold_addr"}, mem_address, hold_a);
                check({tag, "/hold_data"}, mem_data_out, hold_d);
                check({tag, "/hold_strobe"}, {30'd0, mem_read, mem_write}, {30'd0, hold_s});
            end
            hold_v = WAIT_EN && (mem_read || mem_write) && !mem_ready;
            hold_a = mem_address;
            hold_d = mem_data_out;
            hold_s = {mem_read, mem_write};
            if (done) begin
                lat = c;
                break;
            end
            if (inject && c == 2) begin
                start    = 1'b1;
                pop      = ~p;
                mask     = 16'hffff;
                sp_index = spi + 4'd1;
            end
        end
        start = 1'b0;
        check({tag, "/latency"}, lat, exp_lat);
        for (int i = 0; i < 16; i++) check($sformatf("%s/r%0d", tag, i), regs[i], mr[i]);
        check({tag, "/n_writes"}, wr_cnt - wb, ea.size());
        for (int k = 0; k < ea.size() && k < wr_cnt - wb; k++) begin
            check($sformatf("%s/wr%0d_addr", tag, k), wr_addr[wb + k], ea[k]);
            check($sformatf("%s/wr%0d_data", tag, k), wr_data[wb + k], ed[k]);
        end
        check({tag, "/dec_cycles"}, dec_cyc - db, p ? 0 : n);
        check({tag, "/inc_cycles"}, inc_cyc - ib, p ? n : 0);
        check({tag, "/fill_cycles"}, rfw_cyc - fb, p ? n : 0);
        if (n == 0) check({tag, "/strobes"}, strobe_cyc - sb, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] rm;
        logic [3:0]  rs;
        int          rw;
        bit          seen;

        repeat (3) @(negedge clock);
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/strobes", {mem_read, mem_write, rf_write, rf_inc, rf_dec}, 0);
        check("rst/mem_address", mem_address, 0);
        check("rst/rf_sp_index", rf_sp_index, 0);
        reset = 1'b0;

        // Directed push / pop pair.
        for (int i = 0; i < 15; i++) load_reg(i[3:0], 32'h100 + i);
        load_reg(4'd15, 32'h1000);
        load_reg(4'd1, 32'h11);
        load_reg(4'd2, 32'h22);
        do_op(1'b0, 16'h0006, 4'd15, 0, 1'b0, "push");
        check("push/mem_ffc", mem_rd(32'h0ffc), 32'h22);
        check("push/mem_ff8", mem_rd(32'h0ff8), 32'h11);
        check("push/sp", regs[15], 32'h0ff8);
        load_reg(4'd1, 32'h0);
        load_reg(4'd2, 32'h0);
        do_op(1'b1, 16'h0006, 4'd15, 0, 1'b0, "pop");
        check("pop/r1", regs[1], 32'h11);
        check("pop/r2", regs[2], 32'h22);
        check("pop/sp", regs[15], 32'h1000);

        // Empty masks, including a mask holding only the SP.
        do_op(1'b0, 16'h0000, 4'd15, 0, 1'b0, "empty_push");
        do_op(1'b0, 16'h8000, 4'd15, 0, 1'b0, "empty_sp");
        do_op(1'b1, 16'h8000, 4'd15, 0, 1'b0, "empty_sp_pop");

        // Wait states.
        load_reg(4'd3, 32'hdeadbeef);
        do_op(1'b0, 16'h0008, 4'd15, 3, 1'b0, "wait_push");
        do_op(1'b1, 16'h0008, 4'd15, 2, 1'b0, "wait_pop");

        // Start pulses while busy must be ignored.
        do_op(1'b0, 16'h00f0, 4'd15, 0, 1'b1, "ign_push");
        do_op(1'b1, 16'h00f0, 4'd15, 1, 1'b1, "ign_pop");

        // Reset during WRITE of a 4-register push.
        @(negedge clock);
        cur_wait = 0; pop = 1'b0; mask = 16'h00f0; sp_index = 4'd15; start = 1'b1;
        @(posedge clock);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (mem_write) seen = 1'b1;
        end
        check("rstmid/reached_write", seen, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rstmid/busy", busy, 0);
        check("rstmid/done", done, 0);
        check("rstmid/mem_write", mem_write, 0);
        check("rstmid/rf_dec", rf_dec, 0);
        @(negedge clock);
        reset = 1'b0;
        do_op(1'b0, 16'h0030, 4'd15, 0, 1'b0, "after_rst");

        // Randomized push/pop pairs with random SP choice, mask and waits.
        for (int it = 0; it < 20; it++) begin
            rs = 4'($urandom_range(0, 15));
            rm = 16'($urandom);
            rw = $urandom_range(0, 2);
            for (int i = 0; i < 16; i++) load_reg(i[3:0], $urandom);
            if ($urandom_range(0, 3) == 0) load_reg(rs, 32'($urandom_range(0, 3) * STEP));
            else                           load_reg(rs, {$urandom} & 32'hffff_fffc);
            do_op(1'b0, rm, rs, rw, 1'b0, $sformatf("rnd%0d_push", it));
            for (int i = 0; i < 16; i++) if (i[3:0] != rs) load_reg(i[3:0], $urandom);
            do_op(1'b1, rm, rs, $urandom_range(0, 2), 1'b0, $sformatf("rnd%0d_pop", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
